// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller.
// Holds the FSM state encoding and the default building geometry.
// Imported by the request scan and the controller top.
package elevator_pkg;

  localparam int LEVELS_DEF      = 8;
  localparam int LEVEL_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_floor_request_scan.sv
// Combinational view of the latched requests relative to one level.
// Zero latency; pure function of the request vectors and the level.
// No backpressure: results are consumed in the same cycle.
module floor_request_scan
  import elevator_pkg::*;
#(
  parameter int LEVELS      = LEVELS_DEF,
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF
) (
  input  logic [LEVELS-1:0]      in_req,
  input  logic [LEVELS-2:0]      up_req,
  input  logic [LEVELS-1:1]      dn_req,
  input  logic [LEVEL_WIDTH-1:0] level,
  output logic                   req_above,
  output logic                   req_below,
  output logic                   here_up,
  output logic                   here_dn,
  output logic                   up_here,
  output logic                   dn_here
);

  logic [LEVELS-1:0] up_full;
  logic [LEVELS-1:0] dn_full;
  logic [LEVELS-1:0] any_req;

  // Widen hall calls to full height (missing calls at the ends read as 0) and scan both sides.
  always_comb begin
    up_full               = '0;
    up_full[LEVELS-2:0]   = up_req;
    dn_full               = '0;
    dn_full[LEVELS-1:1]   = dn_req;
    any_req               = in_req | up_full | dn_full;
    req_above             = 1'b0;
    req_below             = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      if (i > int'(level)) req_above = req_above | any_req[i];
      if (i < int'(level)) req_below = req_below | any_req[i];
    end
    up_here = up_full[level];
    dn_here = dn_full[level];
    here_up = in_req[level] | up_here;
    here_dn = in_req[level] | dn_here;
  end

endmodule

// File: rtl/elevator_controller.sv
// Collective up/down scan controller: moves the car and opens the door at served levels.
// Outputs registered; door opens one cycle after a serviceable request is seen.
// Served requests are acknowledged by one-cycle inactivate pulses back to the latch block.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int LEVELS        = LEVELS_DEF,
  parameter int LEVEL_WIDTH   = LEVEL_WIDTH_DEF,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEVELS-1:0]      active_in_levels,
  input  logic [LEVELS-2:0]      active_out_up_levels,
  input  logic [LEVELS-1:1]      active_out_down_levels,
  output logic [LEVELS-1:0]      inactivate_in_levels,
  output logic [LEVELS-2:0]      inactivate_out_up_levels,
  output logic [LEVELS-1:1]      inactivate_out_down_levels,
  output logic [LEVEL_WIDTH-1:0] current_level,
  output logic                   direction_up,
  output logic                   moving,
  output logic                   door_open
);

  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  state_t                 state, state_nx;
  logic [LEVEL_WIDTH-1:0] level_nx, scan_level;
  logic                   dir_nx;
  logic [TW-1:0]          travel_cnt, travel_nx;
  logic [DW-1:0]          door_cnt, door_nx;
  logic [LEVELS-1:0]      clr_in_nx;
  logic [LEVELS-2:0]      clr_up_nx;
  logic [LEVELS-1:1]      clr_dn_nx;

  logic arrive, in_here, hall_dir, hall_opp, req_ahead, serve_here, keep_dir;
  logic restart_in, restart_hall, open_door;
  logic req_above, req_below, here_up, here_dn, up_here, dn_here;

  // On the arrival cycle the decision is taken for the level being entered, not the one left.
  assign arrive     = ((state == MOVE_UP) || (state == MOVE_DOWN)) &&
                      (travel_cnt == TW'(TRAVEL_CYCLES - 1));
  assign scan_level = !arrive ? current_level :
                      (state == MOVE_UP) ? current_level + 1'b1 : current_level - 1'b1;

  floor_request_scan #(
    .LEVELS      (LEVELS),
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_scan (
    .in_req    (active_in_levels),
    .up_req    (active_out_up_levels),
    .dn_req    (active_out_down_levels),
    .level     (scan_level),
    .req_above (req_above),
    .req_below (req_below),
    .here_up   (here_up),
    .here_dn   (here_dn),
    .up_here   (up_here),
    .dn_here   (dn_here)
  );

  // An opposite-direction hall call here is deferred while work remains ahead.
  assign in_here      = active_in_levels[scan_level];
  assign hall_dir     = direction_up ? up_here : dn_here;
  assign hall_opp     = direction_up ? dn_here : up_here;
  assign req_ahead    = direction_up ? req_above : req_below;
  assign serve_here   = (direction_up ? here_up : here_dn) | (hall_opp & ~req_ahead);
  assign keep_dir     = req_ahead | hall_dir;
  // A bit whose clear pulse is on this cycle is still latched; do not count it as a new press.
  assign restart_in   = in_here & ~inactivate_in_levels[scan_level];
  assign restart_hall = direction_up ? (up_here & ~inactivate_out_up_levels[scan_level])
                                     : (dn_here & ~inactivate_out_down_levels[scan_level]);

  // Next-state, timers and clear-pulse generation.
  always_comb begin
    state_nx  = state;
    level_nx  = current_level;
    dir_nx    = direction_up;
    travel_nx = travel_cnt;
    door_nx   = door_cnt;
    clr_in_nx = '0;
    clr_up_nx = '0;
    clr_dn_nx = '0;
    open_door = 1'b0;
    case (state)
      IDLE: begin
        if (serve_here) begin
          open_door = 1'b1;
        end else if (req_above && req_below) begin
          state_nx  = direction_up ? MOVE_UP : MOVE_DOWN;
          travel_nx = '0;
        end else if (req_above) begin
          state_nx  = MOVE_UP;
          dir_nx    = 1'b1;
          travel_nx = '0;
        end else if (req_below) begin
          state_nx  = MOVE_DOWN;
          dir_nx    = 1'b0;
          travel_nx = '0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (arrive) begin
          level_nx  = scan_level;
          travel_nx = '0;
          if (serve_here)      open_door = 1'b1;
          else if (!req_ahead) state_nx  = IDLE;
        end else begin
          travel_nx = travel_cnt + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (restart_in || restart_hall) begin
          door_nx = '0;
          clr_in_nx[scan_level] = restart_in;
          if (restart_hall && direction_up)  clr_up_nx[scan_level] = 1'b1;
          if (restart_hall && !direction_up) clr_dn_nx[scan_level] = 1'b1;
        end else if (door_cnt == DW'(DOOR_CYCLES - 1)) begin
          state_nx = IDLE;
          door_nx  = '0;
        end else begin
          door_nx = door_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (open_door) begin
      state_nx = DOOR_OPEN;
      door_nx  = '0;
      dir_nx   = keep_dir ? direction_up : ~direction_up;
      clr_in_nx[scan_level] = in_here;
      if (dir_nx && up_here)  clr_up_nx[scan_level] = 1'b1;
      if (!dir_nx && dn_here) clr_dn_nx[scan_level] = 1'b1;
    end
  end

  // State, position, timers and registered clear pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                      <= IDLE;
      current_level              <= '0;
      direction_up               <= 1'b1;
      travel_cnt                 <= '0;
      door_cnt                   <= '0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else begin
      state                      <= state_nx;
      current_level              <= level_nx;
      direction_up               <= dir_nx;
      travel_cnt                 <= travel_nx;
      door_cnt                   <= door_nx;
      inactivate_in_levels       <= clr_in_nx;
      inactivate_out_up_levels   <= clr_up_nx;
      inactivate_out_down_levels <= clr_dn_nx;
    end
  end

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed vector table, async reset mid-travel,
// then random button presses checked every cycle against a floor-rule model.
// The bench plays the role of the button latch block, clearing bits on pulses.
module tb_elevator_controller;

  localparam int L = 8;
  localparam int T = 4;
  localparam int D = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in;
  logic [6:0] a_up;
  logic [7:1] a_dn;
  logic [7:0] i_in;
  logic [6:0] i_up;
  logic [7:1] i_dn;
  logic [2:0] cur_lvl;
  logic       dir_up, mov, door;

  elevator_controller #(
    .LEVELS(L), .LEVEL_WIDTH(3), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset),
    .active_in_levels(a_in), .active_out_up_levels(a_up), .active_out_down_levels(a_dn),
    .inactivate_in_levels(i_in), .inactivate_out_up_levels(i_up),
    .inactivate_out_down_levels(i_dn),
    .current_level(cur_lvl), .direction_up(dir_up), .moving(mov), .door_open(door)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Button latch contents (hall up at top and hall down at bottom kept 0).
  bit [7:0] lat_in, lat_up, lat_dn;
  bit [7:0] prev_in, prev_up, prev_dn;

  // Reference model: 0 parked, 1 rising, 2 falling, 3 doors open.
  int       m_mode, m_lvl, m_tt, m_dt;
  bit       m_dir;
  bit [7:0] m_pin, m_pup, m_pdn;

  localparam logic [27:0] RST_OBS = {3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 7'h00};

  function automatic bit call_at(int f);
    return lat_in[f] | lat_up[f] | lat_dn[f];
  endfunction

  function automatic bit any_beyond(int f, bit goup);
    for (int g = 0; g < L; g++)
      if ((goup ? (g > f) : (g < f)) && call_at(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hall(int f, bit goup);
    return goup ? lat_up[f] : lat_dn[f];
  endfunction

  // Passengers here going our way, or the last pickup before turning around.
  function automatic bit should_stop(int f, bit d);
    return lat_in[f] | hall(f, d) | (hall(f, !d) & !any_beyond(f, d));
  endfunction

  task automatic open_doors(int f);
    m_mode = 3;
    m_dt   = 0;
    if (!(any_beyond(f, m_dir) | hall(f, m_dir))) m_dir = !m_dir;
    m_pin[f] = lat_in[f];
    if (m_dir) m_pup[f] = lat_up[f];
    else       m_pdn[f] = lat_dn[f];
  endtask

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_dir = 1'b1; m_tt = 0; m_dt = 0;
    m_pin = '0; m_pup = '0; m_pdn = '0;
  endtask

  task automatic model_step();
    bit [7:0] old_in, old_up, old_dn;
    bit a, b, rin, rh;
    old_in = m_pin; old_up = m_pup; old_dn = m_pdn;
    m_pin = '0; m_pup = '0; m_pdn = '0;
    case (m_mode)
      0: begin
        a = any_beyond(m_lvl, 1'b1);
        b = any_beyond(m_lvl, 1'b0);
        if (should_stop(m_lvl, m_dir)) open_doors(m_lvl);
        else if (a && b) begin m_mode = m_dir ? 1 : 2; m_tt = 0; end
        else if (a) begin m_mode = 1; m_dir = 1'b1; m_tt = 0; end
        else if (b) begin m_mode = 2; m_dir = 1'b0; m_tt = 0; end
      end
      1, 2: begin
        if (m_tt == T - 1) begin
          m_lvl = m_lvl + ((m_mode == 1) ? 1 : -1);
          m_tt  = 0;
          if (should_stop(m_lvl, m_dir)) open_doors(m_lvl);
          else if (!any_beyond(m_lvl, m_dir)) m_mode = 0;
        end else begin
          m_tt++;
        end
      end
      default: begin
        rin = lat_in[m_lvl] & !old_in[m_lvl];
        rh  = m_dir ? (lat_up[m_lvl] & !old_up[m_lvl]) : (lat_dn[m_lvl] & !old_dn[m_lvl]);
        if (rin | rh) begin
          m_dt = 0;
          m_pin[m_lvl] = rin;
          if (m_dir) m_pup[m_lvl] = rh;
          else       m_pdn[m_lvl] = rh;
        end else if (m_dt == D - 1) begin
          m_mode = 0; m_dt = 0;
        end else begin
          m_dt++;
        end
      end
    endcase
  endtask

  function automatic logic [27:0] exp_obs();
    return {3'(m_lvl), m_dir, (m_mode == 1) || (m_mode == 2), m_mode == 3,
            m_pin, m_pup[6:0], m_pdn[7:1]};
  endfunction

  function automatic logic [27:0] dut_obs();
    return {cur_lvl, dir_up, mov, door, i_in, i_up, i_dn};
  endfunction

  task automatic check(string name, logic [27:0] act, logic [27:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (lvl,dir,mov,door,in,up,dn)", name, act, want);
    end
  endtask

  task automatic drive();
    a_in = lat_in;
    a_up = lat_up[6:0];
    a_dn = lat_dn[7:1];
  endtask

  // One clock: update latch with presses and last cycle's clears, compare, step model.
  task automatic cycle(bit [7:0] pi, bit [7:0] pu, bit [7:0] pd);
    lat_in = (lat_in & ~prev_in) | pi;
    lat_up = ((lat_up & ~prev_up) | pu) & 8'h7F;
    lat_dn = ((lat_dn & ~prev_dn) | pd) & 8'hFE;
    drive();
    @(negedge clk);
    check("cycle", dut_obs(), exp_obs());
    prev_in = m_pin; prev_up = m_pup; prev_dn = m_pdn;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    lat_in = '0; lat_up = '0; lat_dn = '0;
    prev_in = '0; prev_up = '0; prev_dn = '0;
    drive();
    #1;
    check("reset_async", dut_obs(), RST_OBS);
    @(posedge clk);
    #1;
    check("reset_hold", dut_obs(), RST_OBS);
    reset = 1'b0;
  endtask

  typedef struct {
    bit       rst;
    bit [7:0] pi, pu, pd;
    int       n;
    bit [2:0] lvl;
    bit       dir, mv, dr;
    bit [7:0] ip;
    bit [6:0] up, dp;
  } vec_t;

  function automatic vec_t mk(bit rst, bit [7:0] pi, bit [7:0] pu, bit [7:0] pd, int n,
                              bit [2:0] lvl, bit dir, bit mv, bit dr,
                              bit [7:0] ip, bit [6:0] up, bit [6:0] dp);
    vec_t v;
    v.rst = rst; v.pi = pi; v.pu = pu; v.pd = pd; v.n = n;
    v.lvl = lvl; v.dir = dir; v.mv = mv; v.dr = dr; v.ip = ip; v.up = up; v.dp = dp;
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    reset = 1'b1;
    a_in = '0; a_up = '0; a_dn = '0;
    //           rst  pin    pup    pdn   n   lvl dir mv dr  ip     up     dp
    tbl[0]  = mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[1]  = mk(0, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h01, 7'h00, 7'h00);
    tbl[2]  = mk(0, 8'h00, 8'h00, 8'h00, 5, 0, 0, 0, 1, 8'h00, 7'h00, 7'h00);
    tbl[3]  = mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[4]  = mk(0, 8'h20, 8'h00, 8'h00, 1, 0, 1, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[5]  = mk(0, 8'h00, 8'h00, 8'h00, 4, 1, 1, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[6]  = mk(0, 8'h00, 8'h00, 8'h00, 16, 5, 0, 0, 1, 8'h20, 7'h00, 7'h00);
    tbl[7]  = mk(0, 8'h00, 8'h00, 8'h00, 6, 5, 0, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[8]  = mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[9]  = mk(0, 8'h40, 8'h08, 8'h08, 1, 0, 1, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[10] = mk(0, 8'h00, 8'h00, 8'h00, 12, 3, 1, 0, 1, 8'h00, 7'h08, 7'h00);
    tbl[11] = mk(0, 8'h00, 8'h00, 8'h00, 6, 3, 1, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[12] = mk(0, 8'h00, 8'h00, 8'h00, 1, 3, 1, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[13] = mk(0, 8'h00, 8'h00, 8'h00, 12, 6, 0, 0, 1, 8'h40, 7'h00, 7'h00);
    tbl[14] = mk(0, 8'h00, 8'h00, 8'h00, 6, 6, 0, 0, 0, 8'h00, 7'h00, 7'h00);
    tbl[15] = mk(0, 8'h00, 8'h00, 8'h00, 1, 6, 0, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[16] = mk(0, 8'h00, 8'h00, 8'h00, 12, 3, 0, 0, 1, 8'h00, 7'h00, 7'h04);
    tbl[17] = mk(1, 8'h00, 8'h00, 8'h20, 1, 0, 1, 1, 0, 8'h00, 7'h00, 7'h00);
    tbl[18] = mk(0, 8'h00, 8'h00, 8'h00, 20, 5, 0, 0, 1, 8'h00, 7'h00, 7'h10);
    tbl[19] = mk(0, 8'h00, 8'h00, 8'h00, 3, 5, 0, 0, 1, 8'h00, 7'h00, 7'h00);
    tbl[20] = mk(0, 8'h20, 8'h00, 8'h00, 1, 5, 0, 0, 1, 8'h20, 7'h00, 7'h00);
    tbl[21] = mk(0, 8'h00, 8'h00, 8'h00, 5, 5, 0, 0, 1, 8'h00, 7'h00, 7'h00);
    tbl[22] = mk(0, 8'h00, 8'h00, 8'h00, 1, 5, 0, 0, 0, 8'h00, 7'h00, 7'h00);

    for (int r = 0; r < 23; r++) begin
      if (tbl[r].rst) do_reset();
      for (int k = 0; k < tbl[r].n; k++) begin
        if (k == 0) cycle(tbl[r].pi, tbl[r].pu, tbl[r].pd);
        else        cycle(8'h00, 8'h00, 8'h00);
      end
      check($sformatf("vec%0d", r), dut_obs(),
            {tbl[r].lvl, tbl[r].dir, tbl[r].mv, tbl[r].dr, tbl[r].ip, tbl[r].up, tbl[r].dp});
    end

    // Reset asserted between levels 3 and 4 while rising.
    do_reset();
    cycle(8'h80, 8'h00, 8'h00);
    for (int k = 0; k < 14; k++) cycle(8'h00, 8'h00, 8'h00);
    check("mid_travel", dut_obs(), {3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 7'h00, 7'h00});
    #2;
    do_reset();

    // Random presses against the model.
    for (int c = 0; c < 3000; c++) begin
      bit [7:0] pi, pu, pd;
      int f;
      pi = '0; pu = '0; pd = '0;
      if ($urandom_range(0, 7) == 0) begin
        f = $urandom_range(0, L - 1);
        case ($urandom_range(0, 2))
          0:       pi[f] = 1'b1;
          1:       pu[f] = 1'b1;
          default: pd[f] = 1'b1;
        endcase
      end
      cycle(pi, pu, pd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
